// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the parametrised mux/scanner.
//   state_t     : controller state (IDLE, DIRECT, SCAN)
//   MODE_DIRECT : mode input value selecting the external select
//   MODE_SCAN   : mode input value selecting the internal scan pointer
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Channel-selection controller: FSM, scan pointer and dwell counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   mode        : MODE_DIRECT / MODE_SCAN
//   sel         : direct select, or scan pointer load value
//   load_sel    : in SCAN, load the pointer from sel
//   dwell       : extra cycles each channel is held while scanning
//   en          : global enable
//   cur_ch      : channel to sample at the coming clock edge
//   cur_vld     : cur_ch names a real channel and a sample is taken
//   wrap_nxt    : this sample is the first ch0 sample after a wrap
//
// state  | meaning
// IDLE   | disabled; pointer, dwell count and outputs frozen
// DIRECT | sampling the channel named by sel
// SCAN   | sampling the channel named by the internal pointer
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int SELW    = $clog2(NCH),
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic               load_sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               en,
  output logic [SELW-1:0]    cur_ch,
  output logic               cur_vld,
  output logic               wrap_nxt
);

  localparam logic [SELW:0]   NCH_V = (SELW + 1)'(NCH);
  localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

  state_t             state, state_nxt;
  logic [SELW-1:0]    ptr, ptr_nxt;
  logic [DWELL_W-1:0] dcnt, dcnt_nxt, dcnt_eff;
  logic               wrapped, wrapped_nxt;
  logic               sel_ok;

  // Pointer wraps modulo NCH, so select values NCH..2^SELW-1 are illegal.
  assign sel_ok = {1'b0, sel} < NCH_V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      dcnt    <= '0;
      wrapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      dcnt    <= dcnt_nxt;
      wrapped <= wrapped_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    dcnt_nxt    = dcnt;
    wrapped_nxt = wrapped;
    cur_ch      = ptr;
    cur_vld     = 1'b0;
    wrap_nxt    = 1'b0;
    // Entering SCAN from DIRECT always starts a fresh dwell.
    dcnt_eff    = (state == DIRECT) ? '0 : dcnt;

    if (!en)                    state_nxt = IDLE;
    else if (mode == MODE_SCAN) state_nxt = SCAN;
    else                        state_nxt = DIRECT;

    // Actions follow the state being entered so a sample is taken in the
    // same cycle the inputs ask for it (one-cycle latency to out_data).
    case (state_nxt)
      DIRECT: begin
        cur_ch      = sel;
        cur_vld     = sel_ok;
        if (sel_ok) ptr_nxt = sel;
        dcnt_nxt    = '0;
        wrapped_nxt = 1'b0;
      end
      SCAN: begin
        cur_ch      = ptr;
        cur_vld     = 1'b1;
        wrap_nxt    = wrapped;
        wrapped_nxt = 1'b0;
        if (load_sel && sel_ok) begin
          ptr_nxt  = sel;
          dcnt_nxt = '0;
        end else if (dcnt_eff >= dwell) begin
          // >= also covers a dwell that was lowered below the running count
          dcnt_nxt = '0;
          if (ptr == LAST) begin
            ptr_nxt     = '0;
            wrapped_nxt = 1'b1;
          end else begin
            ptr_nxt = ptr + SELW'(1);
          end
        end else begin
          dcnt_nxt = dcnt_eff + DWELL_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_mux_scanner.sv
// NCH:1, WIDTH-bit multiplexer with registered output; channel chosen
// directly by sel or by a dwell-timed scan pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : channel k at bits [k*WIDTH +: WIDTH]
//   mode       : 0 = DIRECT, 1 = SCAN
//   sel        : direct select / scan pointer load value
//   load_sel   : SCAN pointer load strobe
//   dwell      : each scanned channel is held dwell+1 cycles
//   en         : global enable
//   out_data   : registered selected channel
//   out_ch     : channel index that produced out_data
//   out_valid  : out_data/out_ch hold a valid sample
//   wrap       : one-cycle pulse with the first ch0 sample after a wrap
module param_mux_scanner
  import mux_scan_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NCH     = 4,
  parameter int SELW    = $clog2(NCH),
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 load_sel,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 en,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  output logic                 wrap
);

  localparam int IDXW = $clog2(NCH * WIDTH);

  logic [SELW-1:0]  cur_ch;
  logic             cur_vld;
  logic             wrap_nxt;
  logic [IDXW-1:0]  base;
  logic [WIDTH-1:0] ch_data;

  mux_scan_ctrl #(
    .NCH     (NCH),
    .SELW    (SELW),
    .DWELL_W (DWELL_W)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .load_sel (load_sel),
    .dwell    (dwell),
    .en       (en),
    .cur_ch   (cur_ch),
    .cur_vld  (cur_vld),
    .wrap_nxt (wrap_nxt)
  );

  assign base    = IDXW'(cur_ch) * IDXW'(WIDTH);
  assign ch_data = in_data[base +: WIDTH];

  // An illegal select may point past in_data; cur_vld gates it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (en) begin
      out_data  <= cur_vld ? ch_data : '0;
      out_ch    <= cur_ch;
      out_valid <= cur_vld;
      wrap      <= wrap_nxt;
    end else begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end
  end

endmodule
